// File: rtl/line_buffer_ctrl_pkg.sv
//----------------------------------------------------------------------------
// line_buffer_ctrl_pkg : shared definitions for the line buffer sequencer
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef LOG2
`define LOG2(x) ($clog2(x))
`endif

package line_buffer_ctrl_pkg;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_t;

endpackage

`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
//----------------------------------------------------------------------------
// line_buffer_ctrl : pixel-stream sequencer for a convolution line buffer
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef LOG2
`define LOG2(x) ($clog2(x))
`endif

module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter  int FILTER_SIZE = 3,
    parameter  int IMAGE_SIZE  = 28,
    localparam int DEPTH       = IMAGE_SIZE - (FILTER_SIZE - 1),
    localparam int AW          = `LOG2(IMAGE_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          lb_clk_en,
    output logic [AW-1:0] lb_wr_addr,
    output logic [AW-1:0] lb_rd_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_x,
    output logic [AW-1:0] out_y,
    output logic          out_last
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(IMAGE_SIZE - 1);
    localparam logic [AW-1:0] PRIME_ROW = AW'(FILTER_SIZE - 2);
    localparam logic [AW-1:0] EDGE      = AW'(FILTER_SIZE - 1);
    localparam logic [AW-1:0] PTR_MAX   = AW'(DEPTH - 1);

    lb_state_t     state;
    lb_state_t     state_next;
    logic [AW-1:0] col;
    logic [AW-1:0] row;
    logic [AW-1:0] ptr;
    logic          accept;
    logic          row_end;
    logic          frame_end;
    logic          qualify;

    // The line buffer must not shift while a window is still waiting downstream.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign lb_clk_en  = accept;
    assign row_end    = (col == LAST_IDX);
    assign frame_end  = row_end && (row == LAST_IDX);
    assign qualify    = accept && (state == STREAM) && (col >= EDGE);

    assign lb_wr_addr = ptr;
    assign lb_rd_addr = (ptr == PTR_MAX) ? '0 : ptr + AW'(1);

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && row_end && (row == PRIME_ROW)) state_next = STREAM;
            STREAM:  if (accept && frame_end)                      state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            ptr <= '0;
        end else if (accept) begin
            if (row_end) begin
                col <= '0;
                row <= frame_end ? '0 : row + AW'(1);
            end else begin
                col <= col + AW'(1);
            end
            // Frame end realigns the circular pointer so every frame starts at 0.
            ptr <= (frame_end || (ptr == PTR_MAX)) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else if (qualify) begin
            out_valid <= 1'b1;
            out_x     <= col - EDGE;
            out_y     <= row - EDGE;
            out_last  <= frame_end;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire
